// File: rtl/edge_frame_ctrl.sv
// -----------------------------------------------------------------------------
// edge_frame_ctrl
//
// Frame sequencer placed between a host and the edgedetect pipeline
// (gray FIFO in, sobel/image FIFO out). One start admits exactly one frame of
// IMG_WIDTH*IMG_HEIGHT pixels into the pipeline. Host reads are gated until the
// same number of result pixels has been drained. A one-cycle done pulse then
// marks the frame as complete. A watchdog aborts a frame when no transfer
// happens in either direction for TIMEOUT_CYCLES consecutive busy cycles.
//
// The edgedetect block produces exactly one output pixel per input pixel, so
// matching the input and output counts is enough to know the frame is drained.
//
// Ports
//   clock       in   1      single clock, rising edge
//   reset       in   1      asynchronous, active-low
//   start       in   1      begin a frame (sampled only while idle)
//   host_wr_en  in   1      host pixel write request
//   host_full   out  1      host must not write
//   pipe_wr_en  out  1      to edgedetect gray_wr_en
//   pipe_full   in   1      from edgedetect gray_full
//   host_rd_en  in   1      host result read request
//   host_empty  out  1      no result readable
//   pipe_rd_en  out  1      to edgedetect img_rd_en
//   pipe_empty  in   1      from edgedetect img_empty
//   busy        out  1      frame in progress (loading or draining)
//   done        out  1      one-cycle pulse, frame complete
//   timeout     out  1      sticky watchdog flag, cleared by an accepted start
//   in_count    out  CNT_W  pixels accepted this frame
//   out_count   out  CNT_W  pixels delivered this frame
//
// All handshake outputs are combinational pass-through with zero latency.
// State, counters and flags update on the following rising edge.
// -----------------------------------------------------------------------------
module edge_frame_ctrl #(
   parameter  int IMG_WIDTH      = 720,
   parameter  int IMG_HEIGHT     = 540,
   parameter  int TIMEOUT_CYCLES = 65536,
   localparam int FRAME_PIXELS   = IMG_WIDTH * IMG_HEIGHT,
   localparam int CNT_W          = $clog2(FRAME_PIXELS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             host_wr_en,
   output logic             host_full,
   output logic             pipe_wr_en,
   input  logic             pipe_full,
   input  logic             host_rd_en,
   output logic             host_empty,
   output logic             pipe_rd_en,
   input  logic             pipe_empty,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] in_count,
   output logic [CNT_W-1:0] out_count
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_PIXELS);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // ---------------------------------------------------------------------------
   // State and next-state signals
   // ---------------------------------------------------------------------------
   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [WDOG_W-1:0] wdog;
   logic [WDOG_W-1:0] wdog_nxt;
   logic              timeout_nxt;
   logic [CNT_W-1:0]  in_count_nxt;
   logic [CNT_W-1:0]  out_count_nxt;

   logic              in_ok;
   logic              out_ok;
   logic              xfer;
   logic [CNT_W-1:0]  in_step;
   logic [CNT_W-1:0]  out_step;

   // ---------------------------------------------------------------------------
   // Handshake gating (combinational)
   // ---------------------------------------------------------------------------
   // Input side is open only while loading and the frame is not yet full.
   // The output side stays open through LOAD as well as DRAIN, so results can
   // be read while the rest of the frame is still being written.
   assign in_ok  = (state == ST_LOAD) && (in_count < FRAME_CNT);
   assign out_ok = ((state == ST_LOAD) || (state == ST_DRAIN)) &&
                   (out_count < FRAME_CNT);

   assign host_full  = ~in_ok  | pipe_full;
   assign host_empty = ~out_ok | pipe_empty;
   assign pipe_wr_en = host_wr_en & ~host_full;
   assign pipe_rd_en = host_rd_en & ~host_empty;

   assign busy = (state == ST_LOAD) || (state == ST_DRAIN);
   assign done = (state == ST_DONE);
   assign xfer = pipe_wr_en | pipe_rd_en;

   // Counter values after this cycle's accepted transfers; both may step at once.
   assign in_step  = in_count  + CNT_W'(pipe_wr_en);
   assign out_step = out_count + CNT_W'(pipe_rd_en);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt     = state;
      wdog_nxt      = wdog;
      timeout_nxt   = timeout;
      in_count_nxt  = in_step;
      out_count_nxt = out_step;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt     = ST_LOAD;
               in_count_nxt  = '0;
               out_count_nxt = '0;
               wdog_nxt      = '0;
               timeout_nxt   = 1'b0;
            end
         end

         ST_LOAD: begin
            // The last input pixel can coincide with the last output pixel;
            // in that case DRAIN has nothing left to do and is skipped.
            if (in_step == FRAME_CNT) begin
               state_nxt = (out_step == FRAME_CNT) ? ST_DONE : ST_DRAIN;
            end
         end

         ST_DRAIN: begin
            if (out_step == FRAME_CNT) begin
               state_nxt = ST_DONE;
            end
         end

         ST_DONE: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Watchdog: counts consecutive busy cycles without any transfer. When it
      // expires the frame is abandoned with no done pulse. Counters are left
      // untouched so the stall point can be inspected.
      if (busy) begin
         if (xfer) begin
            wdog_nxt = '0;
         end else if (wdog == WDOG_LAST) begin
            timeout_nxt = 1'b1;
            state_nxt   = ST_IDLE;
         end else begin
            wdog_nxt = wdog + WDOG_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wdog      <= '0;
         timeout   <= 1'b0;
         in_count  <= '0;
         out_count <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // values from before this edge, independent of statement order.
         state     <= state_nxt;
         wdog      <= wdog_nxt;
         timeout   <= timeout_nxt;
         in_count  <= in_count_nxt;
         out_count <= out_count_nxt;
      end
   end

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_edge_frame_ctrl
//
// Self-checking bench for edge_frame_ctrl with a 4x3 frame (12 pixels) and a
// 16-cycle watchdog. The edgedetect pipeline is stood in for by a queue of
// configurable depth that echoes every written pixel. A frame-level reference
// model (pixels accepted, pixels delivered, idle streak, flags) predicts every
// output each cycle.
// -----------------------------------------------------------------------------
module tb_edge_frame_ctrl;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int FP = W * H;
   localparam int TO = 16;
   localparam int CW = $clog2(FP + 1);

   logic          clock      = 1'b0;
   logic          reset      = 1'b0;
   logic          start      = 1'b0;
   logic          host_wr_en = 1'b0;
   logic          host_rd_en = 1'b0;
   logic          pipe_full  = 1'b0;
   logic          pipe_empty = 1'b1;
   logic          host_full;
   logic          pipe_wr_en;
   logic          host_empty;
   logic          pipe_rd_en;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] in_count;
   logic [CW-1:0] out_count;

   int n_checks = 0;
   int n_errors = 0;

   // Pipeline stand-in
   int q[$];
   int depth   = 16;
   int pix_seq = 0;

   // Frame-level reference model
   bit m_active;   // frame in progress
   bit m_done;     // completion cycle
   bit m_to;       // watchdog fired
   int m_in;
   int m_out;
   int m_idle;     // consecutive busy cycles without transfer

   edge_frame_ctrl #(
      .IMG_WIDTH      (W),
      .IMG_HEIGHT     (H),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .host_wr_en (host_wr_en),
      .host_full  (host_full),
      .pipe_wr_en (pipe_wr_en),
      .pipe_full  (pipe_full),
      .host_rd_en (host_rd_en),
      .host_empty (host_empty),
      .pipe_rd_en (pipe_rd_en),
      .pipe_empty (pipe_empty),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .in_count   (in_count),
      .out_count  (out_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_to     = 1'b0;
      m_in     = 0;
      m_out    = 0;
      m_idle   = 0;
      q.delete();
   endtask

   // One clock cycle. fmode/emode: 0 = pipe flag from queue, 1 = forced 1,
   // 2 = forced 0. Inputs are driven just after a rising edge, outputs are
   // checked on the falling edge, and the model then advances.
   task automatic cycle(input bit st, input bit wr, input bit rd,
                        input int fmode = 0, input int emode = 0);
      bit writable, readable, e_full, e_empty, e_wr, e_rd;
      start      = st;
      host_wr_en = wr;
      host_rd_en = rd;
      pipe_full  = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'b0 : (q.size() >= depth);
      pipe_empty = (emode == 1) ? 1'b1 : (emode == 2) ? 1'b0 : (q.size() == 0);
      @(negedge clock);

      writable = m_active && (m_in  < FP);
      readable = m_active && (m_out < FP);
      e_full   = !writable || pipe_full;
      e_empty  = !readable || pipe_empty;
      e_wr     = wr && !e_full;
      e_rd     = rd && !e_empty;

      check("host_full",  host_full,  e_full);
      check("host_empty", host_empty, e_empty);
      check("pipe_wr_en", pipe_wr_en, e_wr);
      check("pipe_rd_en", pipe_rd_en, e_rd);
      check("busy",       busy,       m_active);
      check("done",       done,       m_done);
      check("timeout",    timeout,    m_to);
      check("in_count",   in_count,   m_in);
      check("out_count",  out_count,  m_out);

      if (e_wr) q.push_back(pix_seq++);
      if (e_rd && q.size() > 0) void'(q.pop_front());

      if (m_done) begin
         m_done = 1'b0;
      end else if (!m_active) begin
         if (st) begin
            m_active = 1'b1;
            m_in     = 0;
            m_out    = 0;
            m_idle   = 0;
            m_to     = 1'b0;
         end
      end else begin
         m_in  += int'(e_wr);
         m_out += int'(e_rd);
         if (e_wr || e_rd) begin
            m_idle = 0;
         end else if (m_idle == TO - 1) begin
            m_to     = 1'b1;
            m_active = 1'b0;
         end else begin
            m_idle++;
         end
         if (m_active && m_in == FP && m_out == FP) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b0;
      start      = 1'b0;
      host_wr_en = 1'b0;
      host_rd_en = 1'b0;
      pipe_full  = 1'b0;
      pipe_empty = 1'b1;
      model_clear();
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   // Write and read freely until the frame ends; an expired budget is a failure.
   task automatic finish_frame(input int budget);
      int n = 0;
      while ((m_active || m_done) && n < budget) begin
         cycle(1'b0, 1'b1, 1'b1);
         n++;
      end
      check("frame_budget", m_active || m_done, 1'b0);
   endtask

   initial begin
      model_clear();

      // Reset state, with a write request held high to prove it is blocked.
      host_wr_en = 1'b1;
      host_rd_en = 1'b1;
      pipe_empty = 1'b0;
      @(negedge clock);
      check("rst_busy",       busy,       1'b0);
      check("rst_done",       done,       1'b0);
      check("rst_timeout",    timeout,    1'b0);
      check("rst_host_full",  host_full,  1'b1);
      check("rst_host_empty", host_empty, 1'b1);
      check("rst_pipe_wr_en", pipe_wr_en, 1'b0);
      check("rst_pipe_rd_en", pipe_rd_en, 1'b0);
      check("rst_in_count",   in_count,   0);
      check("rst_out_count",  out_count,  0);
      do_reset();

      // 1+2: full write burst, overflow write, drain, read after completion.
      depth = 16;
      cycle(1'b1, 1'b0, 1'b0);
      repeat (FP) cycle(1'b0, 1'b1, 1'b0);
      check("t1_in_at_drain", in_count, FP);
      check("t1_busy_drain",  busy,     1'b1);
      cycle(1'b0, 1'b1, 1'b0);                   // 13th pixel must be dropped
      check("t2_in_hold",     in_count, FP);
      repeat (FP) cycle(1'b0, 1'b0, 1'b1);
      check("t1_done",        done,      1'b1);
      check("t1_out",         out_count, FP);
      cycle(1'b0, 1'b0, 1'b1);                   // read in DONE is refused
      check("t1_done_once",   done,      1'b0);
      cycle(1'b0, 1'b0, 1'b1);                   // and in IDLE
      check("t1_idle_hold",   out_count, FP);

      // 3: backpressure from the pipeline while the host keeps writing.
      cycle(1'b1, 1'b0, 1'b0);
      repeat (4) cycle(1'b0, 1'b1, 1'b1);
      repeat (5) cycle(1'b0, 1'b1, 1'b0, 1);
      check("t3_in_frozen", in_count, 4);
      finish_frame(80);
      check("t3_in",  in_count,  FP);
      check("t3_out", out_count, FP);

      // 4: last write and last read in the same cycle go straight to DONE.
      cycle(1'b1, 1'b0, 1'b0);
      repeat (FP - 1) cycle(1'b0, 1'b1, 1'b0);
      repeat (FP - 1) cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, 0, 2);
      check("t4_done_direct", done, 1'b1);
      check("t4_not_busy",    busy, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);

      // 5: stall after five writes until the watchdog fires.
      cycle(1'b1, 1'b0, 1'b0);
      repeat (5) cycle(1'b0, 1'b1, 1'b0);
      repeat (14) cycle(1'b0, 1'b0, 1'b0);
      check("t5_still_busy", busy, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, 1'b0);
      check("t5_timeout", timeout,  1'b1);
      check("t5_idle",    busy,     1'b0);
      check("t5_no_done", done,     1'b0);
      check("t5_in_kept", in_count, 5);
      cycle(1'b1, 1'b0, 1'b0);
      check("t5_to_clr",  timeout,   1'b0);
      check("t5_in_clr",  in_count,  0);
      check("t5_out_clr", out_count, 0);
      do_reset();

      // 6: asynchronous reset in the middle of draining.
      cycle(1'b1, 1'b0, 1'b0);
      repeat (FP) cycle(1'b0, 1'b1, 1'b0);
      repeat (7) cycle(1'b0, 1'b0, 1'b1);
      check("t6_out7", out_count, 7);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_busy", busy,      1'b0);
      check("t6_rst_full", host_full, 1'b1);
      check("t6_rst_in",   in_count,  0);
      check("t6_rst_out",  out_count, 0);
      do_reset();
      // start held high during a frame has no effect
      cycle(1'b1, 1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b1, 1'b0);
      check("t6_start_ignored", in_count, 3);
      finish_frame(80);

      // Randomized frames against the model.
      for (int f = 0; f < 24; f++) begin
         int pw;
         int pr;
         depth = $urandom_range(1, 6);
         pw    = (f % 6 == 5) ? 4 : $urandom_range(30, 95);
         pr    = (f % 6 == 5) ? 4 : $urandom_range(30, 95);
         cycle(1'b1, 1'b0, 1'b0);
         for (int c = 0; c < 300 && (m_active || m_done); c++) begin
            cycle($urandom_range(0, 9) == 0,
                  $urandom_range(0, 99) < pw,
                  $urandom_range(0, 99) < pr,
                  ($urandom_range(0, 19) == 0) ? 1 : 0);
         end
         if (m_to || m_active) do_reset();
         repeat ($urandom_range(0, 2)) cycle($urandom_range(0, 1) == 1 ? 1'b0 : 1'b0, 1'b1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL sim_time_limit: got %0t expected completion", $time);
      $fatal(1, "time limit");
   end

endmodule
